// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bit positions, ID/EX register layout and stall FSM encodings.
package id_ex_stage_pkg;

    localparam int XLEN          = 32;
    localparam int CTRL_WIDTH    = 8;
    localparam int REG_IDX_WIDTH = 5;
    localparam int FUNCT_WIDTH   = 4;

    // id_ctrl = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    localparam int CTRL_ALUSRC    = 7;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_REGWRITE  = 5;
    localparam int CTRL_MEMREAD   = 4;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } idex_state_e;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0]    ctrl;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          rs1_data;
        logic [XLEN-1:0]          rs2_data;
        logic [XLEN-1:0]          imm;
        logic [REG_IDX_WIDTH-1:0] rs1;
        logic [REG_IDX_WIDTH-1:0] rs2;
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [FUNCT_WIDTH-1:0]   funct;
        logic                     valid;
    } idex_regs_t;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use detector: a load in EX whose rd feeds the instruction in ID.
import id_ex_stage_pkg::*;

module hazard_unit (
    input  logic                     ex_valid,
    input  logic                     ex_mem_read,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd,
    input  logic                     id_valid,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2,
    output logic                     load_use
);

    // x0 never carries a dependency, so a load targeting it cannot cause a stall.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional stall/flush event counters are built when IDEX_STALL_CNT_EN is defined.
import id_ex_stage_pkg::*;

module id_ex_stage (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CTRL_WIDTH-1:0]    id_ctrl,
    input  logic [XLEN-1:0]          id_pc,
    input  logic [XLEN-1:0]          id_rs1_data,
    input  logic [XLEN-1:0]          id_rs2_data,
    input  logic [XLEN-1:0]          id_imm,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2,
    input  logic [REG_IDX_WIDTH-1:0] id_rd,
    input  logic [FUNCT_WIDTH-1:0]   id_funct,
    input  logic                     id_valid,
    input  logic                     ex_flush,
    output logic [CTRL_WIDTH-1:0]    ex_ctrl,
    output logic [XLEN-1:0]          ex_pc,
    output logic [XLEN-1:0]          ex_rs1_data,
    output logic [XLEN-1:0]          ex_rs2_data,
    output logic [XLEN-1:0]          ex_imm,
    output logic [REG_IDX_WIDTH-1:0] ex_rs1,
    output logic [REG_IDX_WIDTH-1:0] ex_rs2,
    output logic [REG_IDX_WIDTH-1:0] ex_rd,
    output logic [FUNCT_WIDTH-1:0]   ex_funct,
    output logic                     ex_valid,
    output logic                     pc_write,
`ifdef IDEX_STALL_CNT_EN
    output logic [XLEN-1:0]          stall_cnt,
    output logic [XLEN-1:0]          flush_cnt,
`endif
    output logic                     ifid_write
);

    idex_regs_t  regs_q, regs_d;
    idex_state_e state_q, state_d;
    logic        load_use;
    logic        stall;

    hazard_unit u_hazard (
        .ex_valid    (regs_q.valid),
        .ex_mem_read (regs_q.ctrl[CTRL_MEMREAD]),
        .ex_rd       (regs_q.rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    // A taken redirect in EX wins: the front end must move, so no freeze.
    assign stall = load_use && !ex_flush;

    always_comb begin
        regs_d     = '0;
        state_d    = ST_RUN;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (ex_flush) begin
            state_d = ST_RUN;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = (state_q == ST_RUN) ? ST_STALL : ST_RUN;
        end else begin
            regs_d.ctrl     = id_valid ? id_ctrl : '0;
            regs_d.pc       = id_pc;
            regs_d.rs1_data = id_rs1_data;
            regs_d.rs2_data = id_rs2_data;
            regs_d.imm      = id_imm;
            regs_d.rs1      = id_rs1;
            regs_d.rs2      = id_rs2;
            regs_d.rd       = id_rd;
            regs_d.funct    = id_funct;
            regs_d.valid    = id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
        end
    end

    assign ex_ctrl     = regs_q.ctrl;
    assign ex_pc       = regs_q.pc;
    assign ex_rs1_data = regs_q.rs1_data;
    assign ex_rs2_data = regs_q.rs2_data;
    assign ex_imm      = regs_q.imm;
    assign ex_rs1      = regs_q.rs1;
    assign ex_rs2      = regs_q.rs2;
    assign ex_rd       = regs_q.rd;
    assign ex_funct    = regs_q.funct;
    assign ex_valid    = regs_q.valid;

`ifdef IDEX_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall)    stall_cnt_d = stall_cnt_q + 32'd1;
        if (ex_flush) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counter checks are built when IDEX_STALL_CNT_EN is defined.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        id_valid, ex_flush;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic        ex_valid, pc_write, ifid_write;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] CTRL_LW  = 8'b1111_0000;
  localparam logic [7:0] CTRL_ALU = 8'b0010_0010;

  id_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_ctrl     (id_ctrl),
    .id_pc       (id_pc),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_funct    (id_funct),
    .id_valid    (id_valid),
    .ex_flush    (ex_flush),
    .ex_ctrl     (ex_ctrl),
    .ex_pc       (ex_pc),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_funct    (ex_funct),
    .ex_valid    (ex_valid),
    .pc_write    (pc_write),
`ifdef IDEX_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .ifid_write  (ifid_write)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [7:0] ctrl, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] funct, input logic valid);
    id_ctrl     = ctrl;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_funct    = funct;
    id_valid    = valid;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc ^ 32'h0000_5A5A;
    id_imm      = pc + 32'd4;
  endtask

  // advance past the next rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag, input logic [31:0] exp_stall,
                                input logic [31:0] exp_flush);
`ifdef IDEX_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
    check({tag, "_flush_cnt"}, flush_cnt, exp_flush);
`else
    if (tag.len() == 0 && exp_stall != exp_flush) $display("note: counters disabled");
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    ex_flush = 1'b0;
    set_id(8'h00, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0);
    #12;
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_pc_write", 32'(pc_write), 32'h1);
    check("rst_ifid_write", 32'(ifid_write), 32'h1);
    check_counters("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // pass-through
    tick();
    set_id(CTRL_ALU, 32'h100, 5'd1, 5'd2, 5'd5, 4'h0, 1'b1);
    tick();
    check("pass_ex_ctrl", 32'(ex_ctrl), 32'h22);
    check("pass_ex_rd", 32'(ex_rd), 32'd5);
    check("pass_ex_pc", ex_pc, 32'h100);
    check("pass_ex_imm", ex_imm, 32'h104);
    check("pass_ex_rs1_data", ex_rs1_data, 32'hA5A5_0100);
    check("pass_ex_valid", 32'(ex_valid), 32'h1);

    // load-use: lw x3 in EX, consumer reads x3 via rs1
    set_id(CTRL_LW, 32'h104, 5'd1, 5'd2, 5'd3, 4'h2, 1'b1);
    tick();
    check("lu_ex_ctrl_lw", 32'(ex_ctrl), 32'hF0);
    set_id(CTRL_ALU, 32'h108, 5'd3, 5'd4, 5'd6, 4'h8, 1'b1);
    #1;
    check("lu_pc_write", 32'(pc_write), 32'h0);
    check("lu_ifid_write", 32'(ifid_write), 32'h0);
    tick();
    check("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
    check("lu_bubble_valid", 32'(ex_valid), 32'h0);
    check("lu_bubble_rd", 32'(ex_rd), 32'h0);
    check("lu_bubble_pc", ex_pc, 32'h0);
    check("lu_state_stall", 32'(dut.state_q), 32'(ST_STALL));
    check("lu_pc_write_resume", 32'(pc_write), 32'h1);
    tick();
    check("lu_issue_ctrl", 32'(ex_ctrl), 32'h22);
    check("lu_issue_rd", 32'(ex_rd), 32'd6);
    check("lu_issue_funct", 32'(ex_funct), 32'h8);
    check("lu_state_run", 32'(dut.state_q), 32'(ST_RUN));
    check_counters("lu", 32'd1, 32'd0);

    // load to x0 must not stall
    set_id(CTRL_LW, 32'h10C, 5'd1, 5'd2, 5'd0, 4'h2, 1'b1);
    tick();
    set_id(CTRL_ALU, 32'h110, 5'd7, 5'd0, 5'd9, 4'h0, 1'b1);
    #1;
    check("x0_pc_write", 32'(pc_write), 32'h1);
    check("x0_ifid_write", 32'(ifid_write), 32'h1);
    tick();
    check("x0_ex_rd", 32'(ex_rd), 32'd9);
    check("x0_ex_ctrl", 32'(ex_ctrl), 32'h22);

    // flush together with a load-use hazard
    set_id(CTRL_LW, 32'h114, 5'd1, 5'd2, 5'd3, 4'h2, 1'b1);
    tick();
    set_id(CTRL_ALU, 32'h118, 5'd3, 5'd3, 5'd10, 4'h0, 1'b1);
    ex_flush = 1'b1;
    #1;
    check("fl_pc_write", 32'(pc_write), 32'h1);
    check("fl_ifid_write", 32'(ifid_write), 32'h1);
    tick();
    ex_flush = 1'b0;
    check("fl_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("fl_ex_valid", 32'(ex_valid), 32'h0);
    check("fl_state_run", 32'(dut.state_q), 32'(ST_RUN));
    check_counters("fl", 32'd1, 32'd1);

    // invalid ID slot: control zeroed, fields still captured
    set_id(CTRL_ALU, 32'h11C, 5'd1, 5'd2, 5'd12, 4'h0, 1'b0);
    tick();
    check("inv_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("inv_ex_valid", 32'(ex_valid), 32'h0);
    check("inv_ex_rd", 32'(ex_rd), 32'd12);

    // asynchronous reset mid-run
    set_id(CTRL_ALU, 32'h200, 5'd1, 5'd2, 5'd13, 4'h1, 1'b1);
    tick();
    check("pre_rst_ex_rd", 32'(ex_rd), 32'd13);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("arst_ex_rd", 32'(ex_rd), 32'h0);
    check("arst_ex_pc", ex_pc, 32'h0);
    check("arst_ex_valid", 32'(ex_valid), 32'h0);
    check("arst_pc_write", 32'(pc_write), 32'h1);
    check_counters("arst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset taken while in STALL
    set_id(CTRL_LW, 32'h300, 5'd1, 5'd2, 5'd4, 4'h2, 1'b1);
    tick();
    set_id(CTRL_ALU, 32'h304, 5'd8, 5'd4, 5'd14, 4'h0, 1'b1);
    tick();
    check("ms_state_stall", 32'(dut.state_q), 32'(ST_STALL));
    rst_n = 1'b0;
    #1;
    check("ms_state_run", 32'(dut.state_q), 32'(ST_RUN));
    check("ms_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("ms_pc_write", 32'(pc_write), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ms_resume_rd", 32'(ex_rd), 32'd14);
    check("ms_resume_ctrl", 32'(ex_ctrl), 32'h22);

`ifdef IDEX_STALL_CNT_EN
    // stall counter wrap
    set_id(CTRL_LW, 32'h400, 5'd1, 5'd2, 5'd5, 4'h2, 1'b1);
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
    set_id(CTRL_ALU, 32'h404, 5'd5, 5'd2, 5'd15, 4'h0, 1'b1);
    tick();
    check("wrap_stall_cnt", stall_cnt, 32'h0);
    check("wrap_flush_cnt", flush_cnt, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL fix: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_ctrl  in  8  {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]} from ID decode.
REQ-005 id_pc  in  32  PC of ID instruction.
REQ-006 id_rs1_data, id_rs2_data  in  32 each  register-file read data.
REQ-007 id_imm  in  32  sign-extended immediate.
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-009 id_funct  in  4  {inst[30],inst[14:12]} for ALU control.
REQ-010 id_valid  in  1  ID holds a real instruction.
REQ-011 ex_flush  in  1  branch/jump resolved taken in EX; kill ID and ID/EX contents.
REQ-012 ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid  out  (widths as ID)  registered ID/EX outputs.
REQ-013 pc_write  out  1  0 freezes PC.
REQ-014 ifid_write  out  1  0 freezes IF/ID register.
REQ-015 stall_cnt, flush_cnt  out  32 each  present only with IDEX_STALL_CNT_EN.

Function
REQ-016 Load-use hazard (combinational) SHALL assert when ex_valid & ex_ctrl.MemRead & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
REQ-017 On hazard and no ex_flush: pc_write=0, ifid_write=0 same cycle; next edge loads bubble (ex_ctrl=0, ex_valid=0, data fields don't-care but SHALL be zero).
REQ-018 On ex_flush: next edge loads bubble; pc_write=1, ifid_write=1 (front end redirects); flush SHALL override hazard.
REQ-019 Otherwise: next edge captures all id_* fields; ex_valid<=id_valid; ex_ctrl<=id_valid?id_ctrl:0.
REQ-020 Latency exactly 1 cycle ID to EX; no internal buffering beyond one stage.
REQ-021 Stall lasts exactly one cycle per load: after bubble, ex_ctrl.MemRead=0 so hazard clears.
REQ-022 State machine: RUN, STALL. RUN->STALL on hazard&~ex_flush; STALL->RUN unconditionally next cycle; ex_flush in any state -> RUN.
REQ-023 Hazard with ex_rd==0 SHALL NOT stall.

Reset
REQ-024 rst_n low SHALL immediately clear all ex_* outputs to 0, state to RUN, counters to 0.
REQ-025 pc_write and ifid_write SHALL read 1 during and after reset.
REQ-026 Reset deasserted mid-stall SHALL resume in RUN with bubble contents.

Configuration
REQ-027 Macro IDEX_STALL_CNT_EN defined: stall_cnt increments per hazard-stall cycle, flush_cnt per flush cycle, both wrap 0xFFFFFFFF->0.
REQ-028 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-029 Shared package/header holds XLEN=32, CTRL_WIDTH=8, REG_IDX_WIDTH=5, ctrl bit-position constants, state encodings.
REQ-030 Sub-module hazard_unit (combinational load-use detect) SHALL be instantiated inside id_ex_stage.

Verification
REQ-031 Reset: rst_n=0 mid-run -> all ex_* =0, pc_write=ifid_write=1 without clock edge.
REQ-032 Pass-through: id_ctrl=8'b00100010, id_rd=5, id_valid=1 -> next cycle ex_ctrl=8'b00100010, ex_rd=5.
REQ-033 Load-use: ex lw rd=3 (ctrl 8'b11110000), id rs1=3 -> pc_write=ifid_write=0 one cycle, then ex_ctrl=0, then ID instruction issues.
REQ-034 x0 load: ex lw rd=0, id rs2=0 -> no stall.
REQ-035 Flush+hazard same cycle: ex_flush=1 with load-use -> ex_ctrl=0, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-036 Counter wrap (IDEX_STALL_CNT_EN): force stall_cnt=0xFFFFFFFF, one stall -> 0.
